// File: rtl/calc_pkg.sv
// Shared calculator package.
//   - FSM state encoding for the sequential divider (ST_IDLE, ST_RUN, ST_FIN).
//   - Active-low 7-segment constants, bit order g..a:
//     SEG_BLANK (all segments off), SEG_E (error glyph) and the hex glyph table 0-F.
package calc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'b0000110;

   // Entry i is the glyph for hex digit i (entry 0 is the rightmost field).
   localparam logic [15:0][6:0] SEG_GLYPHS = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/hex_to_7seg.sv
// Hex digit to active-low 7-segment decoder (purely combinational).
//   hex  in  4  digit 0-F
//   seg  out 7  active-low segments g..a
module hex_to_7seg
   import calc_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_GLYPHS[hex];

endmodule

// File: rtl/seq_binary_divider.sv
// Multi-cycle restoring (shift-subtract) divider: Q = A / B, R = A % B.
// One quotient bit per cycle, MSB first, with a start/done handshake.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             request, sampled only when idle
//   A [DW-1:0]        dividend, captured on accepted start
//   B [VW-1:0]        divisor, captured on accepted start
//   busy              high while iterating
//   done              one-cycle pulse; Q/R/div_by_zero valid from this cycle
//   Q [DW-1:0]        quotient, held until the next result
//   R [VW-1:0]        remainder, held until the next result
//   div_by_zero       set with done when B was zero; cleared on the next accepted start
// Optional macro DIV_SEG_OUT_EN adds HEX_Q / HEX_R (active-low 7-segment views of Q[3:0] and R).
module seq_binary_divider
   import calc_pkg::*;
#(
   parameter int DW = 4,
   parameter int VW = 2
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] A,
   input  logic [VW-1:0] B,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] Q,
   output logic [VW-1:0] R,
   output logic          div_by_zero
`ifdef DIV_SEG_OUT_EN
   ,
   output logic [6:0]    HEX_Q,
   output logic [6:0]    HEX_R
`endif
);

   localparam int CW = $clog2(DW) + 1;

   state_e        state_q, state_d;
   logic [DW-1:0] dvd_q, dvd_d;      // dividend shifts out MSB first, quotient bits shift in at LSB
   logic [VW:0]   rem_q, rem_d;      // partial remainder, one bit wider than the divisor
   logic [VW-1:0] dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [VW-1:0] res_r_q, res_r_d;
   logic          dbz_q, dbz_d;
   logic          res_load;          // Q/R take a new result this cycle

   logic [VW:0]   rem_shift, rem_next;
   logic [DW-1:0] dvd_next;
   logic          q_bit;

   // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_d  = state_q;
      dvd_d    = dvd_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      quo_d    = quo_q;
      res_r_d  = res_r_q;
      dbz_d    = dbz_q;
      res_load = 1'b0;

      // One restoring step. The remainder stays below the divisor between steps,
      // so the shifted value always fits in VW+1 bits.
      rem_shift = {rem_q[VW-1:0], dvd_q[DW-1]};
      q_bit     = (rem_shift >= {1'b0, dvs_q});
      rem_next  = q_bit ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
      dvd_next  = (dvd_q << 1) | DW'(q_bit);

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               dbz_d = 1'b0;
               if (B != '0) begin
                  state_d = ST_RUN;
                  busy_d  = 1'b1;
                  dvd_d   = A;
                  dvs_d   = B;
                  rem_d   = '0;
                  cnt_d   = '0;
               end else begin
                  // Zero divisor: skip iterating and report immediately.
                  state_d  = ST_FIN;
                  done_d   = 1'b1;
                  quo_d    = '1;
                  res_r_d  = '0;
                  dbz_d    = 1'b1;
                  res_load = 1'b1;
               end
            end
         end
         ST_RUN: begin
            rem_d = rem_next;
            dvd_d = dvd_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DW - 1)) begin
               // Last step: publish the result so it is valid alongside done.
               state_d  = ST_FIN;
               done_d   = 1'b1;
               quo_d    = dvd_next;
               res_r_d  = rem_next[VW-1:0];
               res_load = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dvd_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quo_q   <= '0;
         res_r_q <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quo_q   <= quo_d;
         res_r_q <= res_r_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign Q           = quo_q;
   assign R           = res_r_q;
   assign div_by_zero = dbz_q;

`ifdef DIV_SEG_OUT_EN
   logic [6:0] glyph_q, glyph_r;
   logic [6:0] hex_q_q, hex_q_d, hex_r_q, hex_r_d;

   // Decode the values being loaded so the display registers update on the same edge as Q/R.
   hex_to_7seg u_hex_q (.hex(4'(quo_d)),   .seg(glyph_q));
   hex_to_7seg u_hex_r (.hex(4'(res_r_d)), .seg(glyph_r));

   always_comb begin
      hex_q_d = hex_q_q;
      hex_r_d = hex_r_q;
      if (res_load) begin
         hex_q_d = dbz_d ? SEG_E     : glyph_q;
         hex_r_d = dbz_d ? SEG_BLANK : glyph_r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hex_q_q <= SEG_BLANK;
         hex_r_q <= SEG_BLANK;
      end else begin
         hex_q_q <= hex_q_d;
         hex_r_q <= hex_r_d;
      end
   end

   assign HEX_Q = hex_q_q;
   assign HEX_R = hex_r_q;
`endif

endmodule
